// File: rtl/io_uart_responder_pkg.sv
// Shared constants and types for the io_uart_responder serial console:
// IO direction encoding, 8N1 frame constants and the FSM state encodings.
package io_uart_responder_pkg;

    localparam logic DIRECTION_WRITE = 1'b1;
    localparam logic DIRECTION_READ  = 1'b0;

    localparam logic UART_START     = 1'b0;
    localparam logic UART_STOP      = 1'b1;
    localparam int   UART_DATA_BITS = 8;

    typedef enum logic [1:0] {HS_IDLE, HS_ACK, HS_WAIT_LOW} hs_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Counter width that can hold 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-FF synchronizer, start-bit validation at half bit,
// centre sampling of data bits and stop-bit framing check.
module uart_rx_core
    import io_uart_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 500
) (
    input  logic       new_clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int            TW        = cnt_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST      = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    logic          sync1_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    rx_state_t     state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;

    // Synchronizer, frame sequencing and registered result outputs.
    always_ff @(posedge new_clk) begin
        if (!rst_n) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
            state_r   <= RX_IDLE;
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_byte   <= 8'h00;
            rx_ferr   <= 1'b0;
        end else begin
            sync1_r   <= uart_rx;
            rx_sync_r <= sync1_r;
            rx_prev_r <= rx_sync_r;
            rx_valid  <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    timer_r   <= '0;
                    bit_idx_r <= 3'd0;
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r <= RX_START;
                    end else begin
                        state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (timer_r == HALF_LAST) begin
                        timer_r <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        state_r <= (rx_sync_r == UART_START) ? RX_DATA : RX_IDLE;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                RX_DATA: begin
                    if (timer_r == LAST) begin
                        timer_r   <= '0;
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= RX_STOP;
                        end else begin
                            state_r <= RX_DATA;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                RX_STOP: begin
                    if (timer_r == LAST) begin
                        rx_valid <= 1'b1;
                        rx_byte  <= shift_r;
                        rx_ferr  <= (rx_sync_r != UART_STOP);
                        timer_r  <= '0;
                        state_r  <= RX_IDLE;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                    timer_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/io_uart_responder.sv
// bfcpu io_req/io_ack responder: CPU writes are queued for 8N1 transmission,
// CPU reads block until a received byte is available.
module io_uart_responder
    import io_uart_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 500,
    parameter int TX_DEPTH     = 4,
    parameter int RX_DEPTH     = 2
) (
    input  logic       new_clk,
    input  logic       rst_n,
    input  logic       io_req,
    input  logic       io_dir,
    input  logic [7:0] io_wdata,
    output logic       io_ack,
    output logic [7:0] io_rdata,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int              TW        = cnt_width(CLKS_PER_BIT);
    localparam logic [TW-1:0]   TX_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]   TIMER_ONE = TW'(1);
    localparam int              TXAW      = $clog2(TX_DEPTH);
    localparam int              RXAW      = $clog2(RX_DEPTH);
    localparam logic [TXAW:0]   TX_ONE    = {{TXAW{1'b0}}, 1'b1};
    localparam logic [RXAW:0]   RX_ONE    = {{RXAW{1'b0}}, 1'b1};

    hs_state_t     hs_state_r;
    tx_state_t     tx_state_r;
    logic [TW-1:0] tx_timer_r;
    logic [2:0]    tx_bit_idx_r;
    logic [7:0]    tx_shift_r;

    logic [7:0]    tx_mem_r [TX_DEPTH];
    logic [TXAW:0] tx_wr_ptr_r;
    logic [TXAW:0] tx_rd_ptr_r;
    logic [7:0]    rx_mem_r [RX_DEPTH];
    logic [RXAW:0] rx_wr_ptr_r;
    logic [RXAW:0] rx_rd_ptr_r;

    logic          rx_valid_s;
    logic [7:0]    rx_byte_s;
    logic          rx_ferr_s;

    logic          tx_full_s;
    logic          tx_empty_s;
    logic          rx_full_s;
    logic          rx_empty_s;
    logic          tx_last_s;
    logic          tx_frame_end_s;
    logic          tx_pop_s;
    logic          tx_push_s;
    logic          rx_pop_s;
    logic          rx_push_s;
    logic          rx_drop_s;
    logic          tx_active_nxt_s;
    logic [TXAW:0] tx_wr_nxt_s;
    logic [TXAW:0] tx_rd_nxt_s;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_core (
        .new_clk (new_clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .rx_valid(rx_valid_s),
        .rx_byte (rx_byte_s),
        .rx_ferr (rx_ferr_s)
    );

    // FIFO status and the push/pop decisions shared by all datapaths.
    always_comb begin
        tx_full_s  = (tx_wr_ptr_r[TXAW] != tx_rd_ptr_r[TXAW]) &&
                     (tx_wr_ptr_r[TXAW-1:0] == tx_rd_ptr_r[TXAW-1:0]);
        tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
        rx_full_s  = (rx_wr_ptr_r[RXAW] != rx_rd_ptr_r[RXAW]) &&
                     (rx_wr_ptr_r[RXAW-1:0] == rx_rd_ptr_r[RXAW-1:0]);
        rx_empty_s = (rx_wr_ptr_r == rx_rd_ptr_r);

        tx_last_s      = (tx_timer_r == TX_LAST);
        tx_frame_end_s = (tx_state_r == TX_STOP) && tx_last_s;
        tx_pop_s       = !tx_empty_s && ((tx_state_r == TX_IDLE) || tx_frame_end_s);

        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        tx_push_s = (hs_state_r == HS_IDLE) && io_req && (io_dir == DIRECTION_WRITE) &&
                    (!tx_full_s || tx_pop_s);
        rx_pop_s  = (hs_state_r == HS_IDLE) && io_req && (io_dir != DIRECTION_WRITE) &&
                    !rx_empty_s;
        rx_push_s = rx_valid_s && !rx_ferr_s && (!rx_full_s || rx_pop_s);
        rx_drop_s = rx_valid_s && !rx_ferr_s && rx_full_s && !rx_pop_s;

        tx_wr_nxt_s     = tx_push_s ? (tx_wr_ptr_r + TX_ONE) : tx_wr_ptr_r;
        tx_rd_nxt_s     = tx_pop_s  ? (tx_rd_ptr_r + TX_ONE) : tx_rd_ptr_r;
        tx_active_nxt_s = tx_pop_s || ((tx_state_r != TX_IDLE) && !tx_frame_end_s);
    end

    // CPU handshake: one request level is exactly one push or pop.
    always_ff @(posedge new_clk) begin
        if (!rst_n) begin
            hs_state_r <= HS_IDLE;
            io_ack     <= 1'b0;
            io_rdata   <= 8'h00;
        end else begin
            case (hs_state_r)
                HS_IDLE: begin
                    if (tx_push_s || rx_pop_s) begin
                        hs_state_r <= HS_ACK;
                        io_ack     <= 1'b1;
                    end else begin
                        hs_state_r <= HS_IDLE;
                        io_ack     <= 1'b0;
                    end
                    if (rx_pop_s) begin
                        io_rdata <= rx_mem_r[rx_rd_ptr_r[RXAW-1:0]];
                    end
                end
                HS_ACK: begin
                    if (io_req) begin
                        hs_state_r <= HS_WAIT_LOW;
                    end else begin
                        hs_state_r <= HS_IDLE;
                        io_ack     <= 1'b0;
                    end
                end
                HS_WAIT_LOW: begin
                    if (!io_req) begin
                        hs_state_r <= HS_IDLE;
                        io_ack     <= 1'b0;
                    end else begin
                        hs_state_r <= HS_WAIT_LOW;
                    end
                end
                default: begin
                    hs_state_r <= HS_IDLE;
                    io_ack     <= 1'b0;
                end
            endcase
        end
    end

    // TX FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge new_clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r[TXAW-1:0]] <= io_wdata;
        end
    end

    // TX FIFO pointers.
    always_ff @(posedge new_clk) begin
        if (!rst_n) begin
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
        end else begin
            tx_wr_ptr_r <= tx_wr_nxt_s;
            tx_rd_ptr_r <= tx_rd_nxt_s;
        end
    end

    // TX serializer; a new frame may start on the cycle the stop bit ends.
    always_ff @(posedge new_clk) begin
        if (!rst_n) begin
            tx_state_r   <= TX_IDLE;
            tx_timer_r   <= '0;
            tx_bit_idx_r <= 3'd0;
            tx_shift_r   <= 8'h00;
            uart_tx      <= UART_STOP;
            tx_busy      <= 1'b0;
        end else begin
            tx_busy <= tx_active_nxt_s || (tx_wr_nxt_s != tx_rd_nxt_s);
            if (tx_pop_s) begin
                tx_state_r   <= TX_START;
                tx_timer_r   <= '0;
                tx_bit_idx_r <= 3'd0;
                tx_shift_r   <= tx_mem_r[tx_rd_ptr_r[TXAW-1:0]];
                uart_tx      <= UART_START;
            end else begin
                case (tx_state_r)
                    TX_IDLE: begin
                        tx_timer_r <= '0;
                        uart_tx    <= UART_STOP;
                    end
                    TX_START: begin
                        if (tx_last_s) begin
                            tx_state_r <= TX_DATA;
                            tx_timer_r <= '0;
                            uart_tx    <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        end else begin
                            tx_timer_r <= tx_timer_r + TIMER_ONE;
                        end
                    end
                    TX_DATA: begin
                        if (tx_last_s) begin
                            tx_timer_r <= '0;
                            if (tx_bit_idx_r == 3'(UART_DATA_BITS - 1)) begin
                                tx_state_r <= TX_STOP;
                                uart_tx    <= UART_STOP;
                            end else begin
                                tx_bit_idx_r <= tx_bit_idx_r + 3'd1;
                                uart_tx      <= tx_shift_r[0];
                                tx_shift_r   <= {1'b0, tx_shift_r[7:1]};
                            end
                        end else begin
                            tx_timer_r <= tx_timer_r + TIMER_ONE;
                        end
                    end
                    TX_STOP: begin
                        if (tx_last_s) begin
                            tx_state_r <= TX_IDLE;
                            tx_timer_r <= '0;
                            uart_tx    <= UART_STOP;
                        end else begin
                            tx_timer_r <= tx_timer_r + TIMER_ONE;
                        end
                    end
                    default: begin
                        tx_state_r <= TX_IDLE;
                        uart_tx    <= UART_STOP;
                    end
                endcase
            end
        end
    end

    // RX FIFO storage.
    always_ff @(posedge new_clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r[RXAW-1:0]] <= rx_byte_s;
        end
    end

    // RX FIFO pointers and sticky error flags.
    always_ff @(posedge new_clk) begin
        if (!rst_n) begin
            rx_wr_ptr_r  <= '0;
            rx_rd_ptr_r  <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + RX_ONE;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + RX_ONE;
            end
            rx_overrun   <= rx_overrun | rx_drop_s;
            rx_frame_err <= rx_frame_err | (rx_valid_s & rx_ferr_s);
        end
    end

endmodule

// File: tb/tb_io_uart_responder.sv
// Self-checking bench for io_uart_responder: directed handshake/UART scenarios,
// a vector table and randomized traffic against a frame-level reference model.
module tb_io_uart_responder;
    import io_uart_responder_pkg::*;

    localparam int C     = 8;
    localparam int FRAME = 10 * C;
    localparam int BOUND = 400;

    logic       new_clk;
    logic       rst_n;
    logic       io_req;
    logic       io_dir;
    logic [7:0] io_wdata;
    logic       io_ack;
    logic [7:0] io_rdata;
    logic       uart_rx;
    logic       uart_tx;
    logic       tx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] tx_exp[$];
    int         tx_start_q[$];
    logic [7:0] tx_byte_q[$];

    typedef struct {
        bit         is_tx;
        logic [7:0] stim;
        logic [7:0] exp_rdata;
    } vec_t;

    io_uart_responder #(
        .CLKS_PER_BIT(C),
        .TX_DEPTH    (4),
        .RX_DEPTH    (2)
    ) dut (
        .new_clk     (new_clk),
        .rst_n       (rst_n),
        .io_req      (io_req),
        .io_dir      (io_dir),
        .io_wdata    (io_wdata),
        .io_ack      (io_ack),
        .io_rdata    (io_rdata),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    initial begin
        new_clk = 1'b0;
        forever #5 new_clk = ~new_clk;
    end

    always @(posedge new_clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge new_clk);
        #1;
    endtask

    // Decodes every frame on uart_tx and compares each cycle against the ideal 8N1 waveform.
    initial begin : tx_monitor
        logic [9:0] frame;
        logic [7:0] b;
        int         bad;
        int         st;
        bit         aborted;
        bit         unexpected;
        forever begin
            @(negedge new_clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                st         = cyc;
                unexpected = (tx_exp.size() == 0);
                b          = unexpected ? 8'h00 : tx_exp.pop_front();
                frame      = {1'b1, b, 1'b0};
                bad        = 0;
                aborted    = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k != 0) @(negedge new_clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (uart_tx !== frame[k / C]) bad++;
                end
                if (!aborted) begin
                    tx_start_q.push_back(st);
                    tx_byte_q.push_back(b);
                    check("tx_unexpected_frame", 32'(unexpected), 32'd0);
                    check($sformatf("tx_frame_%02h_bad_cycles", b), bad, 0);
                end
            end
        end
    end

    task automatic cpu_write(input logic [7:0] d, output int lat, output int ack_cyc);
        bit got;
        got     = 1'b0;
        lat     = -1;
        ack_cyc = -1;
        tick();
        tx_exp.push_back(d);
        io_dir   = DIRECTION_WRITE;
        io_wdata = d;
        io_req   = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge new_clk);
            if (io_ack === 1'b1) begin
                got     = 1'b1;
                lat     = i;
                ack_cyc = cyc;
                break;
            end
        end
        if (!got) begin
            check("write_ack_timeout", 32'd0, 32'd1);
            void'(tx_exp.pop_back());
            tick();
            io_req = 1'b0;
            return;
        end
        tick();
        tick();
        @(negedge new_clk);
        check("write_ack_held", io_ack, 1);
        tick();
        io_req = 1'b0;
        @(posedge new_clk);
        @(negedge new_clk);
        check("write_ack_release", io_ack, 0);
    endtask

    task automatic cpu_read(input int bound, output logic [7:0] d, output bit ok, output int lat);
        ok  = 1'b0;
        d   = 8'h00;
        lat = -1;
        tick();
        io_dir = DIRECTION_READ;
        io_req = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(negedge new_clk);
            if (io_ack === 1'b1) begin
                ok  = 1'b1;
                lat = i;
                d   = io_rdata;
                break;
            end
        end
        tick();
        io_req = 1'b0;
        @(posedge new_clk);
        @(negedge new_clk);
        check("read_ack_release", io_ack, 0);
    endtask

    task automatic uart_send(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        tick();
        for (int k = 0; k < 10; k++) begin
            uart_rx = f[k];
            repeat (C) tick();
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_tx_idle(output int c);
        bit done;
        done = 1'b0;
        c    = -1;
        for (int i = 0; i < 60 * FRAME; i++) begin
            @(negedge new_clk);
            if (tx_busy === 1'b0) begin
                c    = cyc;
                done = 1'b1;
                break;
            end
        end
        if (!done) check("tx_idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin : main
        int         lat;
        int         ac;
        int         idle_c;
        int         lat5;
        int         ack5;
        int         n;
        logic [7:0] rd;
        logic [7:0] r;
        bit         ok;
        logic [7:0] rx_model[$];
        vec_t       vecs[6];

        vecs[0] = '{1'b0, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF};
        vecs[2] = '{1'b0, 8'h5A, 8'h5A};
        vecs[3] = '{1'b1, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 8'hFF, 8'h00};
        vecs[5] = '{1'b1, 8'h81, 8'h00};

        rst_n    = 1'b0;
        io_req   = 1'b0;
        io_dir   = DIRECTION_READ;
        io_wdata = 8'h00;
        uart_rx  = 1'b1;
        repeat (3) tick();
        @(negedge new_clk);
        check("reset_io_ack", io_ack, 0);
        check("reset_io_rdata", io_rdata, 0);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_rx_overrun", rx_overrun, 0);
        check("reset_rx_frame_err", rx_frame_err, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // Single write of 0x41: latency, waveform (monitor) and busy release.
        tx_start_q.delete();
        tx_byte_q.delete();
        cpu_write(8'h41, lat, ac);
        check("t1_write_latency", lat, 1);
        check("t1_busy_during_frame", tx_busy, 1);
        wait_tx_idle(idle_c);
        check("t1_frame_count", tx_start_q.size(), 1);
        if (tx_start_q.size() == 1) begin
            check("t1_busy_drop_cycle", idle_c - tx_start_q[0], FRAME);
            check("t1_frame_byte", tx_byte_q[0], 8'h41);
        end

        // Back-to-back writes while a frame is in flight: the 5th stalls until a start bit pops.
        tx_start_q.delete();
        tx_byte_q.delete();
        cpu_write(8'hF0, lat, ac);
        for (int b = 1; b <= 4; b++) begin
            cpu_write(8'(b), lat, ac);
            check($sformatf("t2_write%0d_latency", b), lat, 1);
        end
        cpu_write(8'h05, lat5, ack5);
        check("t2_write5_stalled", 32'(lat5 > 2 * C), 32'd1);
        wait_tx_idle(idle_c);
        check("t2_frame_count", tx_start_q.size(), 6);
        if (tx_start_q.size() == 6) begin
            check("t2_write5_ack_at_pop", ack5, tx_start_q[1]);
            for (int i = 1; i < 6; i++) begin
                check($sformatf("t2_gap_%0d", i), tx_start_q[i] - tx_start_q[i-1], FRAME);
            end
        end

        // Blocking read satisfied by an incoming 0xA5.
        fork
            cpu_read(BOUND, rd, ok, lat);
            uart_send(8'hA5, 1'b1);
        join
        check("t3_read_ok", 32'(ok), 32'd1);
        check("t3_read_data", rd, 8'hA5);
        check("t3_no_ack_before_stop", 32'(lat >= 9 * C + C / 2), 32'd1);
        check("t3_ack_soon_after_stop", 32'(lat <= 10 * C + 4), 32'd1);

        // Short low glitch is rejected at the start-bit recheck.
        tick();
        uart_rx = 1'b0;
        tick();
        tick();
        uart_rx = 1'b1;
        repeat (2 * C) tick();
        check("t5_glitch_overrun", rx_overrun, 0);
        check("t5_glitch_frame_err", rx_frame_err, 0);
        cpu_read(3 * C, rd, ok, lat);
        check("t5_glitch_no_byte", 32'(ok), 32'd0);

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_tx) begin
                cpu_write(vecs[v].stim, lat, ac);
                check($sformatf("vec%0d_write_latency", v), lat, 1);
                wait_tx_idle(idle_c);
            end else begin
                uart_send(vecs[v].stim, 1'b1);
                cpu_read(4 * C, rd, ok, lat);
                check($sformatf("vec%0d_read_ok", v), 32'(ok), 32'd1);
                check($sformatf("vec%0d_read_data", v), rd, vecs[v].exp_rdata);
            end
        end

        // Randomized traffic against the queue model.
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                cpu_write(8'($urandom_range(255, 0)), lat, ac);
            end else begin
                n = $urandom_range(2, 1);
                for (int j = 0; j < n; j++) begin
                    r = 8'($urandom_range(255, 0));
                    rx_model.push_back(r);
                    uart_send(r, 1'b1);
                end
                for (int j = 0; j < n; j++) begin
                    cpu_read(4 * C, rd, ok, lat);
                    r = rx_model.pop_front();
                    check($sformatf("rand%0d_read_ok", it), 32'(ok), 32'd1);
                    check($sformatf("rand%0d_read_data", it), rd, r);
                end
            end
        end
        wait_tx_idle(idle_c);
        check("rand_tx_all_sent", tx_exp.size(), 0);
        check("rand_no_overrun", rx_overrun, 0);

        // Overrun: three frames into a two-entry FIFO.
        uart_send(8'h11, 1'b1);
        uart_send(8'h22, 1'b1);
        uart_send(8'h33, 1'b1);
        repeat (2 * C) tick();
        check("t4_overrun", rx_overrun, 1);
        cpu_read(4 * C, rd, ok, lat);
        check("t4_read1", rd, 8'h11);
        cpu_read(4 * C, rd, ok, lat);
        check("t4_read2", rd, 8'h22);
        cpu_read(3 * C, rd, ok, lat);
        check("t4_third_dropped", 32'(ok), 32'd0);
        check("t4_no_frame_err", rx_frame_err, 0);

        // Framing error: stop bit low.
        uart_send(8'h5A, 1'b0);
        repeat (C) tick();
        check("t5_frame_err", rx_frame_err, 1);
        cpu_read(3 * C, rd, ok, lat);
        check("t5_ferr_no_byte", 32'(ok), 32'd0);

        // Reset mid-frame with one byte still queued.
        cpu_write(8'h3C, lat, ac);
        cpu_write(8'hC3, lat, ac);
        repeat (3 * C) tick();
        rst_n = 1'b0;
        @(posedge new_clk);
        @(negedge new_clk);
        check("t6_uart_tx", uart_tx, 1);
        check("t6_io_ack", io_ack, 0);
        check("t6_tx_busy", tx_busy, 0);
        check("t6_rx_overrun", rx_overrun, 0);
        check("t6_rx_frame_err", rx_frame_err, 0);
        tick();
        rst_n = 1'b1;
        tx_exp.delete();
        tx_start_q.delete();
        tx_byte_q.delete();
        repeat (2 * FRAME) tick();
        check("t6_fifo_flushed", tx_start_q.size(), 0);
        check("t6_idle_after_reset", tx_busy, 0);
        cpu_write(8'h7E, lat, ac);
        check("t6_write_latency", lat, 1);
        wait_tx_idle(idle_c);
        check("t6_frame_count", tx_start_q.size(), 1);
        if (tx_byte_q.size() == 1) begin
            check("t6_frame_byte", tx_byte_q[0], 8'h7E);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
